// File: rtl/writeback_unit.sv
// writeback_unit: merges load results and ALU results into one
// register-file write port. Loads have no backpressure and always win.
// ALU results are bypassed when nothing else is pending and are otherwise
// queued in a small FIFO.
// Optional feature: define WB_LOAD_EXT_EN to sign/zero-extend load data
// according to ld_funct3. Without it, load data passes through unchanged.
module writeback_unit #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [63:0] alu_data,
  input  logic        ld_valid,
  input  logic [4:0]  ld_rd,
  input  logic [63:0] ld_data,
  input  logic [2:0]  ld_funct3,
  output logic        regWrite,
  output logic [4:0]  rd,
  output logic [63:0] data,
  output logic [31:0] busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  // Queue storage and bookkeeping
  logic [4:0]       mem_rd_q   [FIFO_DEPTH];
  logic [4:0]       mem_rd_d   [FIFO_DEPTH];
  logic [63:0]      mem_data_q [FIFO_DEPTH];
  logic [63:0]      mem_data_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Registered write port
  logic        regwrite_q, regwrite_d;
  logic [4:0]  rd_q, rd_d;
  logic [63:0] data_q, data_d;

  // Per-cycle decisions
  logic        alu_accept;
  logic        push;
  logic        pop;
  logic        issue_v;
  logic [4:0]  issue_rd;
  logic [63:0] issue_data;
  logic [63:0] ld_value;
  logic [31:0] busy_c;
  logic [PTR_W-1:0] slot_off;

  // The queue only takes a result when a slot is free before this edge;
  // a pop in the same cycle does not make room early. Held low in reset.
  assign alu_ready  = reset && (count_q < DEPTH_C);
  assign alu_accept = alu_valid && alu_ready;

`ifdef WB_LOAD_EXT_EN
  // Load data shaping by RV64I load type
  always_comb begin
    ld_value = ld_data;
    case (ld_funct3)
      3'b000:  ld_value = {{56{ld_data[7]}},  ld_data[7:0]};
      3'b001:  ld_value = {{48{ld_data[15]}}, ld_data[15:0]};
      3'b010:  ld_value = {{32{ld_data[31]}}, ld_data[31:0]};
      3'b100:  ld_value = {56'd0, ld_data[7:0]};
      3'b101:  ld_value = {48'd0, ld_data[15:0]};
      3'b110:  ld_value = {32'd0, ld_data[31:0]};
      default: ld_value = ld_data;
    endcase
  end
`else
  logic unused_funct3;
  assign unused_funct3 = ^ld_funct3;

  // Load data is written back exactly as read from memory
  always_comb begin
    ld_value = ld_data;
  end
`endif

  // Pick the one write to issue this cycle and decide queue push/pop
  always_comb begin
    push       = 1'b0;
    pop        = 1'b0;
    issue_v    = 1'b0;
    issue_rd   = 5'd0;
    issue_data = 64'd0;
    if (ld_valid) begin
      issue_v    = 1'b1;
      issue_rd   = ld_rd;
      issue_data = ld_value;
      push       = alu_accept;
    end else if (count_q != '0) begin
      issue_v    = 1'b1;
      pop        = 1'b1;
      issue_rd   = mem_rd_q[rd_ptr_q];
      issue_data = mem_data_q[rd_ptr_q];
      push       = alu_accept;
    end else if (alu_accept) begin
      issue_v    = 1'b1;
      issue_rd   = alu_rd;
      issue_data = alu_data;
    end
  end

  // Writes to x0 are consumed but never reach the register file
  always_comb begin
    regwrite_d = issue_v && (issue_rd != 5'd0);
    rd_d       = regwrite_d ? issue_rd : 5'd0;
    data_d     = regwrite_d ? issue_data : 64'd0;
  end

  // Next queue contents, pointers and occupancy
  always_comb begin
    mem_rd_d   = mem_rd_q;
    mem_data_d = mem_data_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push) begin
      mem_rd_d[wr_ptr_q]   = alu_rd;
      mem_data_d[wr_ptr_q] = alu_data;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Scoreboard of destinations still waiting in the queue
  always_comb begin
    busy_c   = 32'd0;
    slot_off = '0;
    for (int j = 0; j < FIFO_DEPTH; j++) begin
      slot_off = PTR_W'(j) - rd_ptr_q;
      if ({1'b0, slot_off} < count_q) begin
        busy_c[mem_rd_q[j]] = 1'b1;
      end
    end
    busy_c[0] = 1'b0;
  end

  // Control state and write port, cleared asynchronously in reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      regwrite_q <= 1'b0;
      rd_q       <= 5'd0;
      data_q     <= 64'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      regwrite_q <= regwrite_d;
      rd_q       <= rd_d;
      data_q     <= data_d;
    end
  end

  // Queue payload; only meaningful where occupancy says so, so no reset
  always_ff @(posedge clk) begin
    mem_rd_q   <= mem_rd_d;
    mem_data_q <= mem_data_d;
  end

  assign regWrite = regwrite_q;
  assign rd       = rd_q;
  assign data     = data_q;
  assign busy     = busy_c;

endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: table-driven directed vectors for writeback_unit plus
// a hand-written mid-operation reset sequence.
module tb_writeback_unit;

  logic        clk;
  logic        reset;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [63:0] alu_data;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [63:0] ld_data;
  logic [2:0]  ld_funct3;
  logic        regWrite;
  logic [4:0]  rd;
  logic [63:0] data;
  logic [31:0] busy;

  int pass_cnt;
  int total_cnt;

  typedef struct {
    logic        ld_v;
    logic [4:0]  ld_r;
    logic [63:0] ld_d;
    logic [2:0]  ld_f3;
    logic        alu_v;
    logic [4:0]  alu_r;
    logic [63:0] alu_d;
    logic        e_we;
    logic [4:0]  e_rd;
    logic [63:0] e_data;
    logic [31:0] e_busy;
    logic        e_ready;
  } vec_t;

  vec_t vecs[$];

  writeback_unit #(.FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .ld_valid  (ld_valid),
    .ld_rd     (ld_rd),
    .ld_data   (ld_data),
    .ld_funct3 (ld_funct3),
    .regWrite  (regWrite),
    .rd        (rd),
    .data      (data),
    .busy      (busy)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string name, input int idx,
                              input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("[TB] FAIL %s (step %0d): got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic add_vec(input logic ld_v, input logic [4:0] ld_r,
                         input logic [63:0] ld_d, input logic [2:0] ld_f3,
                         input logic alu_v, input logic [4:0] alu_r,
                         input logic [63:0] alu_d,
                         input logic e_we, input logic [4:0] e_rd,
                         input logic [63:0] e_data, input logic [31:0] e_busy,
                         input logic e_ready);
    vec_t v;
    v.ld_v = ld_v;   v.ld_r = ld_r;   v.ld_d = ld_d;   v.ld_f3 = ld_f3;
    v.alu_v = alu_v; v.alu_r = alu_r; v.alu_d = alu_d;
    v.e_we = e_we;   v.e_rd = e_rd;   v.e_data = e_data;
    v.e_busy = e_busy; v.e_ready = e_ready;
    vecs.push_back(v);
  endtask

  task automatic apply_stimulus(input logic ld_v, input logic [4:0] ld_r,
                                input logic [63:0] ld_d, input logic [2:0] ld_f3,
                                input logic alu_v, input logic [4:0] alu_r,
                                input logic [63:0] alu_d);
    ld_valid  = ld_v;
    ld_rd     = ld_r;
    ld_data   = ld_d;
    ld_funct3 = ld_f3;
    alu_valid = alu_v;
    alu_rd    = alu_r;
    alu_data  = alu_d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input int idx, input logic e_we, input logic [4:0] e_rd,
                           input logic [63:0] e_data, input logic [31:0] e_busy,
                           input logic e_ready);
    check_output("regWrite",  idx, {63'd0, regWrite},  {63'd0, e_we});
    check_output("rd",        idx, {59'd0, rd},        {59'd0, e_rd});
    check_output("data",      idx, data,               e_data);
    check_output("busy",      idx, {32'd0, busy},      {32'd0, e_busy});
    check_output("alu_ready", idx, {63'd0, alu_ready}, {63'd0, e_ready});
  endtask

  logic [63:0] exp_lb, exp_lh, exp_lw, exp_lhu, exp_lwu;

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    reset = 1'b0;
    apply_stimulus(1'b0, 5'd0, 64'd0, 3'd0, 1'b0, 5'd0, 64'd0);

`ifdef WB_LOAD_EXT_EN
    exp_lb  = 64'hFFFF_FFFF_FFFF_FF80;
    exp_lh  = 64'hFFFF_FFFF_FFFF_8000;
    exp_lw  = 64'hFFFF_FFFF_8000_0000;
    exp_lhu = 64'h0000_0000_0000_DEF0;
    exp_lwu = 64'h0000_0000_8000_0000;
`else
    exp_lb  = 64'h0000_0000_0000_0080;
    exp_lh  = 64'h0000_0000_0000_8000;
    exp_lw  = 64'h0000_0001_8000_0000;
    exp_lhu = 64'h1234_5678_9ABC_DEF0;
    exp_lwu = 64'hFFFF_FFFF_8000_0000;
`endif

    // Vector table: inputs before an edge, outputs seen just after it
    //      ld_v ld_rd  ld_data                ld_f3  alu_v alu_rd alu_data   we rd  data                   busy          ready
    add_vec(0, 5'd0,  64'd0,                 3'd0, 0, 5'd0,  64'd0,      0, 5'd0,  64'd0,                 32'h0,        1);
    add_vec(0, 5'd0,  64'd0,                 3'd0, 1, 5'd5,  64'h1234,   1, 5'd5,  64'h1234,              32'h0,        1);
    add_vec(0, 5'd0,  64'd0,                 3'd0, 0, 5'd0,  64'd0,      0, 5'd0,  64'd0,                 32'h0,        1);
    add_vec(1, 5'd3,  64'd7,                 3'd3, 1, 5'd4,  64'd9,      1, 5'd3,  64'd7,                 32'h10,       1);
    add_vec(0, 5'd0,  64'd0,                 3'd0, 0, 5'd0,  64'd0,      1, 5'd4,  64'd9,                 32'h0,        1);
    add_vec(0, 5'd0,  64'd0,                 3'd0, 1, 5'd0,  64'hFF,     0, 5'd0,  64'd0,                 32'h0,        1);
    add_vec(1, 5'd7,  64'h80,                3'd0, 0, 5'd0,  64'd0,      1, 5'd7,  exp_lb,                32'h0,        1);
    add_vec(1, 5'd8,  64'h80,                3'd4, 0, 5'd0,  64'd0,      1, 5'd8,  64'h80,                32'h0,        1);
    add_vec(1, 5'd9,  64'h8000,              3'd1, 0, 5'd0,  64'd0,      1, 5'd9,  exp_lh,                32'h0,        1);
    add_vec(1, 5'd10, 64'h0000_0001_8000_0000, 3'd2, 0, 5'd0, 64'd0,     1, 5'd10, exp_lw,                32'h0,        1);
    add_vec(1, 5'd11, 64'h1234_5678_9ABC_DEF0, 3'd5, 0, 5'd0, 64'd0,     1, 5'd11, exp_lhu,               32'h0,        1);
    add_vec(1, 5'd12, 64'hFFFF_FFFF_8000_0000, 3'd6, 0, 5'd0, 64'd0,     1, 5'd12, exp_lwu,               32'h0,        1);
    add_vec(1, 5'd13, 64'hDEAD_BEEF_CAFE_F00D, 3'd3, 0, 5'd0, 64'd0,     1, 5'd13, 64'hDEAD_BEEF_CAFE_F00D, 32'h0,      1);
    add_vec(1, 5'd0,  64'd5,                 3'd3, 0, 5'd0,  64'd0,      0, 5'd0,  64'd0,                 32'h0,        1);
    // Fill the queue while loads hold the port
    add_vec(1, 5'd1,  64'h11,                3'd3, 1, 5'd10, 64'hA0,     1, 5'd1,  64'h11,                32'h400,      1);
    add_vec(1, 5'd2,  64'h22,                3'd3, 1, 5'd11, 64'hB0,     1, 5'd2,  64'h22,                32'hC00,      1);
    add_vec(1, 5'd3,  64'h33,                3'd3, 1, 5'd12, 64'hC0,     1, 5'd3,  64'h33,                32'h1C00,     1);
    add_vec(1, 5'd4,  64'h44,                3'd3, 1, 5'd13, 64'hD0,     1, 5'd4,  64'h44,                32'h3C00,     0);
    add_vec(1, 5'd5,  64'h55,                3'd3, 1, 5'd14, 64'hE0,     1, 5'd5,  64'h55,                32'h3C00,     0);
    // Full queue pops while an ALU result is offered: it is not taken
    add_vec(0, 5'd0,  64'd0,                 3'd0, 1, 5'd14, 64'hE0,     1, 5'd10, 64'hA0,                32'h3800,     1);
    add_vec(0, 5'd0,  64'd0,                 3'd0, 1, 5'd15, 64'hF0,     1, 5'd11, 64'hB0,                32'hB000,     1);
    add_vec(0, 5'd0,  64'd0,                 3'd0, 0, 5'd0,  64'd0,      1, 5'd12, 64'hC0,                32'hA000,     1);
    add_vec(0, 5'd0,  64'd0,                 3'd0, 0, 5'd0,  64'd0,      1, 5'd13, 64'hD0,                32'h8000,     1);
    add_vec(0, 5'd0,  64'd0,                 3'd0, 0, 5'd0,  64'd0,      1, 5'd15, 64'hF0,                32'h0,        1);
    add_vec(0, 5'd0,  64'd0,                 3'd0, 0, 5'd0,  64'd0,      0, 5'd0,  64'd0,                 32'h0,        1);
    // x0 entry travelling through the queue
    add_vec(1, 5'd6,  64'd1,                 3'd3, 1, 5'd0,  64'hFF,     1, 5'd6,  64'd1,                 32'h0,        1);
    add_vec(0, 5'd0,  64'd0,                 3'd0, 0, 5'd0,  64'd0,      0, 5'd0,  64'd0,                 32'h0,        1);
    add_vec(0, 5'd0,  64'd0,                 3'd0, 1, 5'd21, 64'h2121,   1, 5'd21, 64'h2121,              32'h0,        1);

    // Reset state while reset is held low
    #12;
    check_all(-1, 1'b0, 5'd0, 64'd0, 32'h0, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i].ld_v, vecs[i].ld_r, vecs[i].ld_d, vecs[i].ld_f3,
                     vecs[i].alu_v, vecs[i].alu_r, vecs[i].alu_d);
      step();
      check_all(i, vecs[i].e_we, vecs[i].e_rd, vecs[i].e_data,
                vecs[i].e_busy, vecs[i].e_ready);
    end

    // Mid-operation reset: three entries queued, write port active
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(1'b1, 5'(20 + k), 64'(k + 1), 3'd3, 1'b1, 5'(16 + k), 64'(k + 100));
      step();
    end
    check_all(100, 1'b1, 5'd22, 64'd3, 32'h0007_0000, 1'b1);
    apply_stimulus(1'b0, 5'd0, 64'd0, 3'd0, 1'b0, 5'd0, 64'd0);
    #2;
    reset = 1'b0;
    #1;
    check_all(101, 1'b0, 5'd0, 64'd0, 32'h0, 1'b0);
    step();
    check_all(102, 1'b0, 5'd0, 64'd0, 32'h0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    step();
    check_all(103, 1'b0, 5'd0, 64'd0, 32'h0, 1'b1);
    apply_stimulus(1'b0, 5'd0, 64'd0, 3'd0, 1'b1, 5'd9, 64'h99);
    step();
    check_all(104, 1'b1, 5'd9, 64'h99, 32'h0, 1'b1);
    apply_stimulus(1'b0, 5'd0, 64'd0, 3'd0, 1'b0, 5'd0, 64'd0);
    step();
    check_all(105, 1'b0, 5'd0, 64'd0, 32'h0, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
